// File: rtl/exec_sequencer_if.sv
// Handshake/bus bundle between the execution sequencer and its fetch, decode
// and data-memory neighbours. The sequencer uses the master view.
interface exec_sequencer_if #(
  parameter int MICRO_LEN = 13
);
  logic                 inst_req;
  logic                 inst_rvalid;
  logic [31:0]          inst_rdata;
  logic [31:0]          inst_q;
  logic [MICRO_LEN-1:0] micro_cmd;
  logic                 hit;
  logic                 dmem_req;
  logic                 dmem_wr;
  logic [1:0]           dmem_size;
  logic                 dmem_ready;
  logic                 reg_we;
  logic                 pc_we;
  logic [2:0]           state;
  logic                 halted;
  logic [1:0]           trap;
  logic [31:0]          retire_cnt;

  modport master (
    output inst_req, inst_q, dmem_req, dmem_wr, dmem_size, reg_we, pc_we,
           state, halted, trap, retire_cnt,
    input  inst_rvalid, inst_rdata, micro_cmd, hit, dmem_ready
  );

  modport slave (
    input  inst_req, inst_q, dmem_req, dmem_wr, dmem_size, reg_we, pc_we,
           state, halted, trap, retire_cnt,
    output inst_rvalid, inst_rdata, micro_cmd, hit, dmem_ready
  );
endinterface

// File: rtl/exec_sequencer.sv
// Multi-cycle instruction sequencer: fetch, decode, execute, optional data
// access with timeout, write-back; ebreak halts and faults trap until reset.
module exec_sequencer #(
  parameter int MICRO_LEN   = 13,
  parameter int MEM_TIMEOUT = 16
) (
  input logic              clk,
  input logic              rst,
  exec_sequencer_if.master bus
);
  localparam int              CNT_W    = $clog2(MEM_TIMEOUT) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_TIMEOUT - 1);
  localparam logic [31:0]      EBREAK   = 32'h0010_0073;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5,
    S_TRAP   = 3'd6
  } state_t;

  state_t               r_state;
  logic [31:0]          r_inst_q;
  logic [MICRO_LEN-1:0] r_micro;
  logic [CNT_W-1:0]     r_tmo_cnt;
  logic [31:0]          r_retire_cnt;
  logic                 r_halted;
  logic [1:0]           r_trap;

  logic       w_regen;
  logic [1:0] w_mwen;
  logic [1:0] w_mren;
  logic       w_has_mem;
  logic       w_unused_micro;

  // Fields not consumed here (PC source, ALU op, immediate type) belong to the datapath.
  assign w_regen        = r_micro[12];
  assign w_mwen         = r_micro[9:8];
  assign w_mren         = r_micro[7:6];
  assign w_has_mem      = (w_mwen != 2'b00) || (w_mren != 2'b00);
  assign w_unused_micro = ^r_micro;

  // Sequencer state machine and its sticky status registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_FETCH;
      r_inst_q     <= 32'd0;
      r_micro      <= '0;
      r_tmo_cnt    <= '0;
      r_retire_cnt <= 32'd0;
      r_halted     <= 1'b0;
      r_trap       <= 2'b00;
    end else begin
      case (r_state)
        S_FETCH: begin
          if (bus.inst_rvalid) begin
            r_inst_q <= bus.inst_rdata;
            r_state  <= S_DECODE;
          end
        end
        S_DECODE: begin
          r_micro <= bus.micro_cmd;
          if (r_inst_q == EBREAK) begin
            r_halted <= 1'b1;
            r_state  <= S_HALT;
          end else if (!bus.hit) begin
            r_trap  <= 2'b01;
            r_state <= S_TRAP;
          end else begin
            r_state <= S_EXEC;
          end
        end
        S_EXEC: begin
          r_tmo_cnt <= '0;
          r_state   <= w_has_mem ? S_MEM : S_WB;
        end
        S_MEM: begin
          // A completing access wins over an expiring timeout in the same cycle.
          if (bus.dmem_ready) begin
            r_state <= S_WB;
          end else if (r_tmo_cnt == CNT_LAST) begin
            r_trap  <= 2'b10;
            r_state <= S_TRAP;
          end else begin
            r_tmo_cnt <= r_tmo_cnt + CNT_W'(1);
          end
        end
        S_WB: begin
          r_retire_cnt <= r_retire_cnt + 32'd1;
          r_state      <= S_FETCH;
        end
        S_HALT:  r_state <= S_HALT;
        S_TRAP:  r_state <= S_TRAP;
        default: r_state <= S_TRAP;
      endcase
    end
  end

  // Output decode from registered state; everything is forced low while in reset.
  always_comb begin
    bus.inst_req   = 1'b0;
    bus.dmem_req   = 1'b0;
    bus.dmem_wr    = 1'b0;
    bus.dmem_size  = 2'b00;
    bus.reg_we     = 1'b0;
    bus.pc_we      = 1'b0;
    bus.state      = 3'd0;
    bus.inst_q     = 32'd0;
    bus.halted     = 1'b0;
    bus.trap       = 2'b00;
    bus.retire_cnt = 32'd0;
    if (!rst) begin
      bus.state      = r_state;
      bus.inst_q     = r_inst_q;
      bus.halted     = r_halted;
      bus.trap       = r_trap;
      bus.retire_cnt = r_retire_cnt;
      case (r_state)
        S_FETCH: bus.inst_req = 1'b1;
        S_MEM: begin
          bus.dmem_req  = 1'b1;
          bus.dmem_wr   = (w_mwen != 2'b00);
          bus.dmem_size = (w_mwen != 2'b00) ? w_mwen : w_mren;
        end
        S_WB: begin
          bus.reg_we = w_regen;
          bus.pc_we  = 1'b1;
        end
        default: bus.inst_req = 1'b0;
      endcase
    end else begin
      bus.inst_req = 1'b0;
    end
  end
endmodule
